// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl -- sequencer for a BF16 dot product on an external 2-stage MAC.
//
// A job reads len operand pairs from two memories, starting at base_a and base_b.
// The MAC accumulates the products, and the FP32 accumulator value is then offered
// through a valid/ready result handshake. Only one job is in flight at a time.
//
// Ports
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   start, len,            job request; sampled only when idle. The length and the
//   base_a, base_b         base addresses are latched together with start.
//   busy                   high whenever a job is in progress
//   rd_en,                 operand read strobe and read addresses; the memories
//   rd_addr_a, rd_addr_b   return data one cycle after rd_en
//   mac_en, mac_clear,     MAC control. mac_zero_op forces the MAC operands to zero
//   mac_zero_op            (external mux) during the drain cycle.
//   acc_in                 accumulator output of the MAC
//   res_valid, res_data,   result handshake. done pulses on the accepting cycle.
//   res_ready, done
module mac_dot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mac_en,
  output logic              mac_clear,
  output logic              mac_zero_op,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LAST, S_FLUSH, S_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_a_q, base_a_d;
  logic [ADDR_W-1:0] base_b_q, base_b_d;
  logic              rden_q;
  logic [ADDR_W-1:0] idx_addr;

  // The index is truncated or extended to the address width, so addresses wrap
  // modulo 2^ADDR_W.
  assign idx_addr = ADDR_W'(idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      rden_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      rden_q   <= rd_en;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    busy        = 1'b1;
    rd_en       = 1'b0;
    mac_clear   = 1'b0;
    mac_zero_op = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d    = len;
          base_a_d = base_a;
          base_b_d = base_b;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        mac_clear = 1'b1;
        idx_d     = '0;
        state_d   = (len_q != '0) ? S_FETCH : S_OUT;
      end
      S_FETCH: begin
        rd_en = 1'b1;
        idx_d = idx_q + 1'b1;
        // len_q is nonzero in this state, so len_q-1 cannot underflow.
        if (idx_q == len_q - 1'b1) state_d = S_LAST;
      end
      S_LAST: begin
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Zero operands push the final product through the MAC's second stage.
        mac_zero_op = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        res_data  = acc_in;
        if (res_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // mac_en follows the read strobe by one cycle. That cycle is when read data
  // arrives, and it also covers LAST. In FLUSH, mac_en is forced on so that the
  // MAC pipeline drains.
  assign mac_en    = rden_q | (state_q == S_FLUSH);
  assign rd_addr_a = rd_en ? base_a_q + idx_addr : '0;
  assign rd_addr_b = rd_en ? base_b_q + idx_addr : '0;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
module tb_mac_dot_ctrl;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] base_a, base_b;
  logic              busy, rd_en, mac_en, mac_clear, mac_zero_op;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [ACC_W-1:0]  acc_in;
  logic              res_valid, res_ready, done;
  logic [ACC_W-1:0]  res_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] da_q = 16'h0, db_q = 16'h0;
  real prod_r = 0.0;
  real acc_r  = 0.0;

  mac_dot_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .base_a(base_a), .base_b(base_b), .busy(busy), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .mac_en(mac_en),
    .mac_clear(mac_clear), .mac_zero_op(mac_zero_op), .acc_in(acc_in),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  // BF16 and FP32 conversion for normal numbers and zero; the test values stay exact.
  function automatic real bf16_to_real(input logic [15:0] h);
    logic [10:0] e;
    if (h[14:0] == 15'h0) return 0.0;
    e = {3'b000, h[14:7]} + 11'd896;
    return $bitstoreal({h[15], e, h[6:0], 45'h0});
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Models for the operand memories (one-cycle read) and the 2-stage MAC.
  always @(posedge clk) begin
    if (rd_en) begin
      da_q <= mem_a[rd_addr_a];
      db_q <= mem_b[rd_addr_b];
    end
  end

  always @(posedge clk) begin
    if (mac_clear) begin
      prod_r <= 0.0;
      acc_r  <= 0.0;
    end else if (mac_en) begin
      prod_r <= mac_zero_op ? 0.0 : bf16_to_real(da_q) * bf16_to_real(db_q);
      acc_r  <= acc_r + prod_r;
    end
  end

  assign acc_in = real_to_fp32(acc_r);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_dot(input int n, input logic [7:0] ba, input logic [7:0] bb);
    real s;
    logic [7:0] aa, ab;
    s = 0.0;
    for (int i = 0; i < n; i++) begin
      aa = ba + 8'(i);
      ab = bb + 8'(i);
      s = s + bf16_to_real(mem_a[aa]) * bf16_to_real(mem_b[ab]);
    end
    return real_to_fp32(s);
  endfunction

  // Checks the control outputs in job cycle cyc, where cycle 0 is the cycle in which start is sampled.
  task automatic step_checks(input int n, input int cyc, input logic [7:0] ba, input logic [7:0] bb);
    logic e_rd, e_en, e_zero;
    logic [7:0] ea, eb;
    e_rd   = (n >= 1) && (cyc >= 2) && (cyc <= n + 1);
    e_en   = (n >= 1) && (cyc >= 3) && (cyc <= n + 3);
    e_zero = (n >= 1) && (cyc == n + 3);
    ea = e_rd ? ba + 8'(cyc - 2) : 8'h0;
    eb = e_rd ? bb + 8'(cyc - 2) : 8'h0;
    check("busy", 32'(busy), 32'(1'b1));
    check("rd_en", 32'(rd_en), 32'(e_rd));
    check("mac_en", 32'(mac_en), 32'(e_en));
    check("mac_clear", 32'(mac_clear), 32'(cyc == 1));
    check("mac_zero_op", 32'(mac_zero_op), 32'(e_zero));
    check("rd_addr_a", 32'(rd_addr_a), 32'(ea));
    check("rd_addr_b", 32'(rd_addr_b), 32'(eb));
  endtask

  task automatic run_job(input int n, input logic [7:0] ba, input logic [7:0] bb,
                         input logic [31:0] expv, input int hold);
    int cyc;
    logic [31:0] held;
    logic [31:0] want;
    @(negedge clk);
    len = n[LEN_W-1:0]; base_a = ba; base_b = bb; start = 1'b1; res_ready = 1'b0;
    exp_q.push_back(expv);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      step_checks(n, cyc, ba, bb);
    end while (!res_valid && cyc < n + 20);
    check("latency", 32'(cyc), 32'((n == 0) ? 2 : n + 4));
    want = exp_q.pop_front();
    check("res_data", res_data, want);
    check("done_wait", 32'(done), 32'(1'b0));
    for (int i = 0; i < hold; i++) begin
      held = res_data;
      if (i == 1) begin
        start = 1'b1; len = 9'd7; base_a = 8'h33; base_b = 8'h44;
      end
      @(negedge clk);
      start = 1'b0;
      check("hold_valid", 32'(res_valid), 32'(1'b1));
      check("hold_data", res_data, held);
      check("hold_done", 32'(done), 32'(1'b0));
    end
    res_ready = 1'b1;
    #1;
    check("done_pulse", 32'(done), 32'(1'b1));
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'(1'b0));
    check("idle_done", 32'(done), 32'(1'b0));
    check("idle_valid", 32'(res_valid), 32'(1'b0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'h0);
    check({tag, "_mac_en"}, 32'(mac_en), 32'h0);
    check({tag, "_mac_clear"}, 32'(mac_clear), 32'h0);
    check({tag, "_zero_op"}, 32'(mac_zero_op), 32'h0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_addr_a"}, 32'(rd_addr_a), 32'h0);
    check({tag, "_addr_b"}, 32'(rd_addr_b), 32'h0);
    check({tag, "_res_data"}, res_data, 32'h0);
  endtask

  initial begin
    logic [15:0] tbl [5];
    logic [31:0] e;
    tbl[0] = 16'h3F80; tbl[1] = 16'h4000; tbl[2] = 16'h3F00; tbl[3] = 16'hBF80; tbl[4] = 16'h4040;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h3F80;
      mem_b[i] = 16'h3F80;
    end
    rst_n = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'h0);

    // len=4, all operands 1.0
    run_job(4, 8'h00, 8'h00, 32'h40800000, 0);
    // len=1, 1.0 x 2.0
    mem_b[0] = 16'h4000;
    run_job(1, 8'h00, 8'h00, 32'h40000000, 0);
    // len=0
    run_job(0, 8'h00, 8'h00, 32'h00000000, 0);
    // back-pressure with an ignored start pulse in OUT
    run_job(2, 8'h08, 8'h08, 32'h40000000, 3);
    // address wrap on base_a
    mem_b[8'h10] = 16'h4000; mem_b[8'h11] = 16'h4000; mem_b[8'h12] = 16'h4000;
    run_job(3, 8'hFE, 8'h10, 32'h40C00000, 0);
    // mixed operand values
    for (int i = 0; i < 5; i++) begin
      mem_a[8'h40 + i] = tbl[$urandom_range(4, 0)];
      mem_b[8'h80 + i] = tbl[$urandom_range(4, 0)];
    end
    e = model_dot(5, 8'h40, 8'h80);
    run_job(5, 8'h40, 8'h80, e, 1);

    // reset in the 2nd FETCH cycle of a len=4 job
    @(negedge clk);
    len = 9'd4; base_a = 8'h00; base_b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_rd_en", 32'(rd_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob");
    @(negedge clk);
    check_all_zero("midjob_hold");
    rst_n = 1'b1;
    run_job(1, 8'h20, 8'h20, 32'h3F800000, 0);

    // maximum length completes without index overflow
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h3F80;
      mem_b[i] = 16'h3F80;
    end
    run_job(511, 8'h05, 8'h90, 32'h43FF8000, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001: Parameter ADDR_W, default 8, operand memory address width.
REQ-002: Parameter LEN_W, default 9, width of the element-count field.
REQ-003: Parameter ACC_W, default 32, FP32 result width.
REQ-004: clk  input  1  clock; all state on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: start  input  1  job request; sampled only in IDLE.
REQ-007: len  input  LEN_W  number of BF16 element pairs; latched with start.
REQ-008: base_a, base_b  input  ADDR_W each  operand start addresses; latched with start.
REQ-009: busy  output  1  high in every state except IDLE.
REQ-010: rd_en  output  1  operand read strobe; memories return data one cycle later.
REQ-011: rd_addr_a, rd_addr_b  output  ADDR_W each  read addresses.
REQ-012: mac_en  output  1  drives the MAC en.
REQ-013: mac_clear  output  1  drives the MAC clear_acc.
REQ-014: mac_zero_op  output  1  forces the MAC operands to 0x0000; external mux.
REQ-015: acc_in  input  ACC_W  MAC acc_out.
REQ-016: res_valid  output  1  result available.
REQ-017: res_data  output  ACC_W  dot-product result.
REQ-018: res_ready  input  1  consumer accepts result.
REQ-019: done  output  1  one-cycle pulse on result handshake.

Function
REQ-020: States SHALL be IDLE, CLEAR, FETCH, LAST, FLUSH, OUT.
REQ-021: IDLE with start=1 SHALL latch len, base_a and base_b, then go to CLEAR.
REQ-022: IDLE with start=0 SHALL stay in IDLE.
REQ-023: CLEAR SHALL last 1 cycle with mac_clear=1 and mac_en=0.
REQ-024: CLEAR SHALL go to FETCH if latched len!=0, otherwise directly to OUT.
REQ-025: FETCH SHALL last exactly len cycles, rd_en=1, element index idx=0..len-1.
REQ-026: rd_addr_a=base_a+idx and rd_addr_b=base_b+idx, wrapping modulo 2^ADDR_W.
REQ-027: mac_en SHALL equal rd_en delayed one cycle, so it is 0 in the first FETCH cycle and 1 in subsequent FETCH cycles.
REQ-028: LAST SHALL last 1 cycle with mac_en=1 and rd_en=0, consuming the final read data.
REQ-029: FLUSH SHALL last 1 cycle with mac_en=1 and mac_zero_op=1, pushing the final product into the accumulator (2-stage MAC drain).
REQ-030: OUT: res_valid=1, res_data=acc_in combinationally, mac_en=0 (accumulator frozen, result stable).
REQ-031: OUT SHALL stay in OUT while res_ready=0.
REQ-032: OUT with res_ready=1: done=1 that cycle, next state IDLE.
REQ-033: Latency for len>=1: start sampled in cycle C0 gives res_valid from cycle C(len+4). For len=0, res_valid from C2 with res_data=0.
REQ-034: start outside IDLE SHALL be ignored; latched len and bases unchanged.
REQ-035: IDLE with start=1 and len=0 SHALL still pass through CLEAR.
REQ-036: mac_zero_op SHALL be 0 in all states except FLUSH.
REQ-037: mac_clear SHALL be 0 in all states except CLEAR.
REQ-038: A single job SHALL never overlap with another job (no pipelining across jobs).
REQ-039: Idx counter width SHALL be LEN_W; len=2^LEN_W-1 SHALL complete without overflow.

Reset
REQ-040: rst_n low SHALL force IDLE immediately.
REQ-041: rst_n low SHALL force busy, rd_en, mac_en, mac_clear, mac_zero_op, res_valid and done to 0.
REQ-042: rst_n low SHALL force rd_addr_a, rd_addr_b, res_data latch, idx and the delayed rd_en to 0.
REQ-043: Reset mid-job SHALL abandon the job with no result and no done.
REQ-044: After reset release, the first start SHALL behave as a fresh job, beginning with CLEAR.

Verification
REQ-045: len=1, base_a=0, base_b=0, mem_a[0]=0x3F80, mem_b[0]=0x4000 -> res_valid at C5, res_data=0x40000000.
REQ-046: len=4, all operands 0x3F80 -> rd_addr 0..3 in C2..C5, mac_en high C3..C7, res_data=0x40800000 at C8, one done pulse.
REQ-047: len=0 -> mac_clear at C1, no rd_en, res_valid at C2, res_data=0x00000000.
REQ-048: res_ready held low 3 cycles in OUT, start pulsed meanwhile -> res_valid and res_data stable, start ignored, done only on the res_ready=1 cycle.
REQ-049: base_a=0xFE, len=3 -> rd_addr_a sequence 0xFE, 0xFF, 0x00.
REQ-050: rst_n asserted in the 2nd FETCH cycle of a len=4 job -> all outputs 0 at once; next job (len=1, 0x3F80x0x3F80) -> res_data=0x3F800000.
